muldiv_ctrl: RTL and testbench

Iterative multiply/divide controller for the EX stage of the pipelined MIPS core. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX, sequences a shared shift-add/subtract datapath over WIDTH cycles, and owns the HI/LO registers. Drives a stall request so the hazard logic holds the pipeline when a new mul/div or an MFHI/MFLO arrives while an operation is in flight.

---
 rtl/muldiv_pkg.sv | 38 +++
 rtl/muldiv_core.sv | 101 ++++++++++
 rtl/muldiv_ctrl.sv | 148 ++++++++++++++
 tb/tb_muldiv_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM states,
// iteration count and small op-decode helpers.
package muldiv_pkg;

   localparam int ITER = 32;

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5
   } muldiv_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2
   } muldiv_state_e;

   function automatic int cnt_width(input int w);
      return $clog2(w) + 1;
   endfunction

   function automatic logic is_arith_op(input logic [2:0] op);
      return (op[2] == 1'b0);
   endfunction

   function automatic logic is_div_op(input logic [2:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   function automatic logic is_signed_op(input logic [2:0] op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/muldiv_core.sv
// Shared shift-add / restoring-divide datapath. Works on magnitudes and applies
// the recorded sign correction when the result is taken.
module muldiv_core
   import muldiv_pkg::*;
#(
   parameter int WIDTH = ITER
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_load,
   input  logic             i_step,
   input  logic             i_fix,
   input  logic [2:0]       i_op,
   input  logic [WIDTH-1:0] i_rs,
   input  logic [WIDTH-1:0] i_rt,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);

   logic               r_is_div;
   logic               r_neg_q;
   logic               r_neg_r;
   logic               r_div_zero;
   logic [WIDTH-1:0]   r_b;
   logic [2*WIDTH:0]   r_acc;

   logic               w_div;
   logic               w_sgn;
   logic               w_rt_zero;
   logic [WIDTH-1:0]   w_a_mag;
   logic [WIDTH-1:0]   w_b_mag;
   logic [WIDTH:0]     w_mul_sum;
   logic [2*WIDTH:0]   w_div_shift;
   logic [WIDTH:0]     w_div_trial;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_rem;
   logic [WIDTH-1:0]   w_quo;

   assign w_div     = is_div_op(i_op);
   assign w_sgn     = is_signed_op(i_op);
   assign w_rt_zero = (i_rt == {WIDTH{1'b0}});
   assign w_a_mag   = (w_sgn && i_rs[WIDTH-1]) ? -i_rs : i_rs;
   assign w_b_mag   = (w_sgn && i_rt[WIDTH-1]) ? -i_rt : i_rt;

   // Accumulator layout: multiply {upper W+1, multiplier W}; divide {remainder W+1, dividend/quotient W}
   assign w_mul_sum   = r_acc[2*WIDTH:WIDTH] + (r_acc[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
   assign w_div_shift = {r_acc[2*WIDTH-1:0], 1'b0};
   assign w_div_trial = w_div_shift[2*WIDTH:WIDTH] - {1'b0, r_b};

   assign w_prod = r_neg_q ? -r_acc[2*WIDTH-1:0] : r_acc[2*WIDTH-1:0];
   assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
   assign w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];

   // Operand latch and one iteration per step strobe
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_is_div   <= 1'b0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_div_zero <= 1'b0;
         r_b        <= {WIDTH{1'b0}};
         r_acc      <= {(2*WIDTH+1){1'b0}};
      end else if (i_load) begin
         r_is_div   <= w_div;
         r_neg_q    <= w_sgn & (i_rs[WIDTH-1] ^ i_rt[WIDTH-1]);
         r_neg_r    <= w_sgn & w_div & i_rs[WIDTH-1];
         r_div_zero <= w_div & w_rt_zero;
         r_b        <= w_div ? w_b_mag : w_a_mag;
         // A zero divisor keeps the raw dividend so the remainder comes out as rsVal itself
         r_acc      <= {{(WIDTH+1){1'b0}}, (w_div ? ((w_rt_zero) ? i_rs : w_a_mag) : w_b_mag)};
      end else if (i_step) begin
         if (r_is_div) begin
            r_acc <= w_div_trial[WIDTH] ? w_div_shift
                                        : {w_div_trial, w_div_shift[WIDTH-1:1], 1'b1};
         end else begin
            r_acc <= {1'b0, w_mul_sum, r_acc[WIDTH-1:1]};
         end
      end
   end

   // Final result selection with sign correction
   always_comb begin
      o_valid = i_fix;
      o_hi    = w_prod[2*WIDTH-1:WIDTH];
      o_lo    = w_prod[WIDTH-1:0];
      if (r_is_div) begin
         if (r_div_zero) begin
            o_hi = r_acc[2*WIDTH-1:WIDTH];
            o_lo = {WIDTH{1'b1}};
         end else begin
            o_hi = w_rem;
            o_lo = w_quo;
         end
      end else begin
         o_hi = w_prod[2*WIDTH-1:WIDTH];
         o_lo = w_prod[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide controller: sequencing FSM, iteration counter, HI/LO registers,
// MTHI/MTLO writes and the stall/done handshake towards the pipeline.
module muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int WIDTH = ITER
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] rsVal,
   input  logic [WIDTH-1:0] rtVal,
   input  logic             readHiLo,
   input  logic             cancel,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             stall
);

   localparam int CW = cnt_width(WIDTH);

   muldiv_state_e    r_state;
   muldiv_state_e    w_next_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic             r_busy;
   logic             r_done;

   logic             w_accept;
   logic             w_load;
   logic             w_step;
   logic             w_fix;
   logic             w_mthi;
   logic             w_mtlo;
   logic             w_cnt_last;
   logic             w_core_valid;
   logic [WIDTH-1:0] w_core_hi;
   logic [WIDTH-1:0] w_core_lo;

   assign w_accept   = start & ~cancel;
   assign w_cnt_last = (r_cnt == CW'(WIDTH - 1));

   muldiv_core #(.WIDTH(WIDTH)) u_core (
      .i_clk   (clk),
      .i_reset (reset),
      .i_load  (w_load),
      .i_step  (w_step),
      .i_fix   (w_fix),
      .i_op    (op),
      .i_rs    (rsVal),
      .i_rt    (rtVal),
      .o_valid (w_core_valid),
      .o_hi    (w_core_hi),
      .o_lo    (w_core_lo)
   );

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic; cancel always wins
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept && is_arith_op(op)) w_next_state = ST_CALC;
            else                             w_next_state = ST_IDLE;
         end
         ST_CALC: begin
            if (cancel)          w_next_state = ST_IDLE;
            else if (w_cnt_last) w_next_state = ST_FIX;
            else                 w_next_state = ST_CALC;
         end
         ST_FIX:  w_next_state = ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Datapath strobes per state
   always_comb begin
      w_load = 1'b0;
      w_step = 1'b0;
      w_fix  = 1'b0;
      w_mthi = 1'b0;
      w_mtlo = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_load = w_accept & is_arith_op(op);
            w_mthi = w_accept & (op == OP_MTHI);
            w_mtlo = w_accept & (op == OP_MTLO);
         end
         ST_CALC: w_step = ~cancel;
         ST_FIX:  w_fix  = ~cancel;
         default: w_load = 1'b0;
      endcase
   end

   // Iteration counter
   always_ff @(posedge clk) begin
      if (reset || w_load) begin
         r_cnt <= {CW{1'b0}};
      end else if (w_step) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // HI/LO ownership: mul/div result or MTxx data
   always_ff @(posedge clk) begin
      if (reset) begin
         r_hi <= {WIDTH{1'b0}};
         r_lo <= {WIDTH{1'b0}};
      end else if (w_core_valid) begin
         r_hi <= w_core_hi;
         r_lo <= w_core_lo;
      end else if (w_mthi) begin
         r_hi <= rsVal;
      end else if (w_mtlo) begin
         r_lo <= rsVal;
      end
   end

   // Registered busy and one-cycle done pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_busy <= (w_next_state != ST_IDLE);
         r_done <= w_core_valid;
      end
   end

   assign hi    = r_hi;
   assign lo    = r_lo;
   assign busy  = r_busy;
   assign done  = r_done;
   assign stall = r_busy & (start | readHiLo);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: hand-computed results, latency, stall, cancel and reset.
module tb_muldiv_ctrl;
   import muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] rsVal = 32'd0;
   logic [31:0] rtVal = 32'd0;
   logic        readHiLo = 1'b0;
   logic        cancel = 1'b0;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;
   logic        stall;

   int n_total = 0;
   int n_bad   = 0;

   muldiv_ctrl #(.WIDTH(32)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .rsVal    (rsVal),
      .rtVal    (rtVal),
      .readHiLo (readHiLo),
      .cancel   (cancel),
      .hi       (hi),
      .lo       (lo),
      .busy     (busy),
      .done     (done),
      .stall    (stall)
   );

   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1;
      op    = o;
      rsVal = a;
      rtVal = b;
      tick();
      start = 1'b0;
   endtask

   // Called in cycle 1 after acceptance; returns the cycle in which done is seen
   task automatic wait_done(output int cyc, output int busy_n);
      cyc    = 1;
      busy_n = 0;
      while (!done && cyc < 100) begin
         if (busy) busy_n++;
         tick();
         cyc++;
      end
   endtask

   task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int c;
      int bn;
      issue(o, a, b);
      wait_done(c, bn);
      chk_eq({tag, "_lat"}, c, 34);
      chk_eq({tag, "_busy"}, bn, 33);
      chk_eq({tag, "_hi"}, hi, exp_hi);
      chk_eq({tag, "_lo"}, lo, exp_lo);
      tick();
      chk_eq({tag, "_pulse"}, done, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int c;
      int bn;
      int sn;
      int dn;

      tick();
      tick();
      chk_eq("rst_hi", hi, 32'h0);
      chk_eq("rst_lo", lo, 32'h0);
      chk_eq("rst_busy", busy, 1'b0);
      chk_eq("rst_done", done, 1'b0);
      reset = 1'b0;
      tick();

      run_op("mult_neg", OP_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      run_op("divu", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
      run_op("div_neg", OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2);
      run_op("div_zero", OP_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
      run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
      run_op("multu_big", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);

      // readHiLo during an operation stalls until the result is visible
      issue(OP_MULTU, 32'd5, 32'd6);
      repeat (9) tick();
      readHiLo = 1'b1;
      #1;
      sn = 0;
      for (int i = 10; i < 34; i++) begin
         if (stall) sn++;
         tick();
      end
      chk_eq("rdhl_stall_n", sn, 24);
      chk_eq("rdhl_stall_end", stall, 1'b0);
      chk_eq("rdhl_done", done, 1'b1);
      chk_eq("rdhl_lo", lo, 32'd30);
      readHiLo = 1'b0;
      tick();

      // start held while busy is accepted the cycle busy drops
      issue(OP_MULTU, 32'd3, 32'd4);
      start = 1'b1;
      op    = OP_MULTU;
      rsVal = 32'd7;
      rtVal = 32'd8;
      sn = 0;
      for (int i = 1; i < 34; i++) begin
         if (stall) sn++;
         tick();
      end
      chk_eq("b2b_stall_n", sn, 33);
      chk_eq("b2b_done1", done, 1'b1);
      chk_eq("b2b_lo1", lo, 32'd12);
      chk_eq("b2b_stall34", stall, 1'b0);
      tick();
      start = 1'b0;
      chk_eq("b2b_busy35", busy, 1'b1);
      wait_done(c, bn);
      chk_eq("b2b_lat68", c + 34, 68);
      chk_eq("b2b_lo2", lo, 32'd56);
      tick();

      // MTHI/MTLO preload, then cancel a divide mid-flight
      issue(OP_MTHI, 32'h11, 32'h0);
      chk_eq("mthi_hi", hi, 32'h11);
      chk_eq("mthi_busy", busy, 1'b0);
      chk_eq("mthi_done", done, 1'b0);
      issue(OP_MTLO, 32'h22, 32'h0);
      chk_eq("mtlo_lo", lo, 32'h22);
      issue(OP_DIVU, 32'd1000, 32'd3);
      repeat (14) tick();
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      chk_eq("cancel_busy", busy, 1'b0);
      dn = 0;
      for (int i = 0; i < 30; i++) begin
         if (done) dn++;
         tick();
      end
      chk_eq("cancel_nodone", dn, 0);
      chk_eq("cancel_hi", hi, 32'h11);
      chk_eq("cancel_lo", lo, 32'h22);

      // cancel beats start in IDLE, also for MTxx; reserved op ignored
      start = 1'b1; op = OP_MULT; rsVal = 32'd9; rtVal = 32'd9; cancel = 1'b1;
      tick();
      chk_eq("cs_busy", busy, 1'b0);
      op = OP_MTHI; rsVal = 32'h99;
      tick();
      chk_eq("cs_mthi", hi, 32'h11);
      cancel = 1'b0; op = 3'd6;
      tick();
      start = 1'b0;
      chk_eq("rsv_busy", busy, 1'b0);
      dn = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) dn++;
         tick();
      end
      chk_eq("cs_nodone", dn, 0);
      chk_eq("cs_lo", lo, 32'h22);

      // reset mid-operation
      issue(OP_MULT, 32'd123, 32'd456);
      repeat (19) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk_eq("mrst_busy", busy, 1'b0);
      chk_eq("mrst_hi", hi, 32'h0);
      chk_eq("mrst_lo", lo, 32'h0);
      chk_eq("mrst_done", done, 1'b0);
      run_op("mult_6x7", OP_MULT, 32'd6, 32'd7, 32'd0, 32'd42);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
